// File: rtl/request_unit_if.sv
// Memory-side bus of the request unit: one outstanding read or write,
// completed in the first cycle the memory drops mem_busy.
interface request_unit_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_busy;

  modport master (
    output mem_addr, mem_wdata, mem_sel, mem_read, mem_write,
    input  mem_rdata, mem_busy
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_sel, mem_read, mem_write,
    output mem_rdata, mem_busy
  );
endinterface

// File: rtl/request_unit.sv
// Sequences instruction fetch and load/store traffic for a simple multi-cycle
// core over a single memory port, with a busy-timeout that parks the unit in HALT.
module request_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instruction_address,
  input  logic [31:0]          data_address,
  input  logic                 dm_read_en,
  input  logic                 dm_write_en,
  input  logic                 store_byte,
  input  logic [31:0]          data_to_write,
  output logic [31:0]          instruction_read,
  output logic [31:0]          data_read,
  output logic                 pc_enable,
  output logic                 bus_error,
  request_unit_if.master       mem
);

  typedef enum logic [1:0] {FETCH, EXEC, DATA, HALT} state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] wait_cnt;
  logic        access_write;
  logic        timed_out;

  // Word accesses only; the PC's low bits never reach the bus.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, instruction_address[1:0]};

  always_comb begin
    state_next    = state;
    timed_out     = 1'b0;
    pc_enable     = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    mem.mem_addr  = {instruction_address[31:2], 2'b00};
    mem.mem_wdata = '0;
    mem.mem_sel   = 4'h0;

    case (state)
      FETCH: begin
        mem.mem_read = 1'b1;
        mem.mem_sel  = 4'hF;
        if (!mem.mem_busy) begin
          state_next = EXEC;
        end else if (wait_cnt == WAIT_LIMIT) begin
          timed_out  = 1'b1;
          state_next = HALT;
        end
      end

      EXEC: begin
        if (dm_write_en || dm_read_en) begin
          state_next = DATA;
        end else begin
          pc_enable  = 1'b1;
          state_next = FETCH;
        end
      end

      DATA: begin
        mem.mem_addr = {data_address[31:2], 2'b00};
        // Direction comes from the latched access type, not the live enables.
        if (access_write) begin
          mem.mem_write = 1'b1;
          if (store_byte) begin
            mem.mem_wdata = {4{data_to_write[7:0]}};
            mem.mem_sel   = 4'b0001 << data_address[1:0];
          end else begin
            mem.mem_wdata = data_to_write;
            mem.mem_sel   = 4'hF;
          end
        end else begin
          mem.mem_read = 1'b1;
          mem.mem_sel  = 4'hF;
        end
        if (!mem.mem_busy) begin
          pc_enable  = 1'b1;
          state_next = FETCH;
        end else if (wait_cnt == WAIT_LIMIT) begin
          timed_out  = 1'b1;
          state_next = HALT;
        end
      end

      HALT: begin
        state_next = HALT;
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= FETCH;
      wait_cnt         <= '0;
      instruction_read <= NOP_INSTR;
      data_read        <= '0;
      bus_error        <= 1'b0;
      access_write     <= 1'b0;
    end else begin
      state <= state_next;

      if (state_next != state) begin
        wait_cnt <= '0;
      end else if ((state == FETCH || state == DATA) && mem.mem_busy) begin
        wait_cnt <= wait_cnt + 16'd1;
      end

      if (state == FETCH && !mem.mem_busy) begin
        instruction_read <= mem.mem_rdata;
      end

      if (state == DATA && !access_write && !mem.mem_busy) begin
        data_read <= mem.mem_rdata;
      end

      if (state == EXEC) begin
        access_write <= dm_write_en;
      end

      if (timed_out) begin
        bus_error <= 1'b1;
      end
    end
  end

endmodule
